// File: rtl/r_handler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r_handler_pkg
// Description : Shared types and constants for the read/write data handlers.
// Revision    : 1.0 - initial release
// ============================================================================
package r_handler_pkg;

  localparam int CNT_W  = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OPERATION = 2'd1,
    ST_SETUP     = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] burst_len;
  } trans_data_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_channel_t;

endpackage
`default_nettype wire

// File: rtl/r_beat_checker.sv
`default_nettype none
// ============================================================================
// Module      : r_beat_checker
// Description : Flags an R beat whose data, resp or last differs from the
//               generator's counting pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module r_beat_checker
  import r_handler_pkg::*;
(
  input  r_channel_t       beat_i,
  input  logic [CNT_W-1:0] beat_idx_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             mismatch_o
);

  logic [CNT_W-1:0]  w_last_idx;
  logic [DATA_W-1:0] w_exp_data;

  // len of 0 wraps to a final index of 255, i.e. a 256-beat burst
  always_comb begin
    w_last_idx = len_i - CNT_W'(1);
    w_exp_data = DATA_W'(beat_idx_i);
    mismatch_o = (beat_i.data != w_exp_data)
              || (beat_i.resp != RESP_OKAY)
              || (beat_i.last != (beat_idx_i == w_last_idx));
  end

endmodule
`default_nettype wire

// File: rtl/r_handler.sv
`default_nettype none
// ============================================================================
// Module      : r_handler
// Description : R-channel consumer; counts beats/bursts of one descriptor and
//               optionally checks each beat (macro R_HANDLER_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module r_handler
  import r_handler_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             r_valid_i,
  input  r_channel_t       r_data_i,
  output logic             r_ready_o,
  input  trans_data_t      trans_data_i,
  input  logic             enable_i,
  output logic             ready_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  trans_data_t      r_trans;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_beat_acc;
  logic             w_last_beat;
  logic             w_last_burst;

  assign w_beat_acc   = r_valid_i && r_ready_o;
  assign w_last_beat  = (r_beat_cnt  == r_trans.len       - CNT_W'(1));
  assign w_last_burst = (r_burst_cnt == r_trans.burst_len - CNT_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (enable_i) w_state_nxt = ST_OPERATION;
      ST_OPERATION: if (w_beat_acc && w_last_beat) w_state_nxt = ST_SETUP;
      ST_SETUP:     w_state_nxt = w_last_burst ? ST_IDLE : ST_OPERATION;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o   = 1'b0;
    r_ready_o = 1'b0;
    done_o    = 1'b0;
    case (r_state)
      ST_IDLE:      ready_o   = 1'b1;
      ST_OPERATION: r_ready_o = 1'b1;
      ST_SETUP:     done_o    = w_last_burst;
      default:      ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trans     <= '0;
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_trans     <= trans_data_i;
          r_beat_cnt  <= '0;
          r_burst_cnt <= '0;
        end
        ST_OPERATION: if (w_beat_acc) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        ST_SETUP: begin
          r_beat_cnt <= '0;
          if (!w_last_burst) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef R_HANDLER_CHECK_EN
  logic             w_mismatch;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  r_beat_checker u_beat_checker (
    .beat_i     (r_data_i),
    .beat_idx_i (r_beat_cnt),
    .len_i      (r_trans.len),
    .mismatch_o (w_mismatch)
  );

  // errors stay visible while idle and clear only when the next transaction starts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if ((r_state == ST_IDLE) && enable_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_beat_acc && w_mismatch) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
`else
  logic w_unused_beat;
  assign w_unused_beat = ^r_data_i;
  assign err_o         = 1'b0;
  assign err_cnt_o     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_r_handler.sv
`default_nettype none
// ============================================================================
// Module      : tb_r_handler
// Description : Randomized self-checking bench for r_handler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r_handler;
  import r_handler_pkg::*;

`ifdef R_HANDLER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        r_valid;
  r_channel_t  r_data;
  logic        r_ready;
  trans_data_t trans;
  logic        enable;
  logic        ready;
  logic        done;
  logic        err;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_prev = 0;   // erroneous beats of the last transaction (sticky while idle)
  int plan[$];        // forced corruption kinds for the next beats: 0 ok, 1 data, 2 resp, 3 last

  always #5 clk = ~clk;

  r_handler dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .r_valid_i    (r_valid),
    .r_data_i     (r_data),
    .r_ready_o    (r_ready),
    .trans_data_i (trans),
    .enable_i     (enable),
    .ready_o      (ready),
    .done_o       (done),
    .err_o        (err),
    .err_cnt_o    (err_cnt)
  );

  function automatic logic [7:0] model_cnt(input int n);
    return CHK ? ((n > 255) ? 8'd255 : 8'(n)) : 8'd0;
  endfunction

  function automatic r_channel_t make_beat(input int idx, input int len, input int kind);
    r_channel_t b;
    b.data = DATA_W'(idx);
    b.resp = 2'b00;
    b.last = (idx == len - 1);
    case (kind)
      1:       b.data = DATA_W'(idx + 5);
      2:       b.resp = 2'b10;
      3:       b.last = ~b.last;
      default: ;
    endcase
    return b;
  endfunction

  function automatic r_channel_t junk_beat();
    r_channel_t b;
    b.data = $urandom;
    b.resp = 2'($urandom);
    b.last = 1'($urandom);
    return b;
  endfunction

  // One descriptor: len/blen raw 8-bit values (0 means 256); abort_after>0 resets after that many beats.
  task automatic run_trans(input int len, input int blen, input int cpct, input int kind_def,
                           input int vpct, input int abort_after);
    int L, B, beat, burst, errs, acc, cyc, ph, kind, limit;
    bit fin;
    L = (len == 0) ? 256 : len;
    B = (blen == 0) ? 256 : blen;
    beat = 0; burst = 0; errs = 0; acc = 0; cyc = 0; ph = 0; fin = 0;
    limit = B * (L + 1) * 20 + 50;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || err_cnt !== model_cnt(exp_prev)) begin
      failures++;
      $display("FAIL idle_before_start ready=%b err_cnt=%0d expected ready=1 err_cnt=%0d",
               ready, err_cnt, model_cnt(exp_prev));
    end
    trans.len = 8'(len); trans.burst_len = 8'(blen);
    enable = 1'b1; r_valid = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    trans  = trans_data_t'($urandom);
    while (!fin) begin
      cyc++;
      if (cyc > limit) begin
        checks++; failures++;
        $display("FAIL timeout cycles=%0d expected done within %0d", cyc, B * (L + 1));
        break;
      end
      if (abort_after > 0 && acc == abort_after) begin
        rst = 1'b1; r_valid = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || r_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
          failures++;
          $display("FAIL reset_mid ready=%b r_ready=%b done=%b err=%b err_cnt=%0d expected 1 0 0 0 0",
                   ready, r_ready, done, err, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0; exp_prev = 0;
        return;
      end
      checks++;
      if (err !== (CHK && errs > 0) || err_cnt !== model_cnt(errs)) begin
        failures++;
        $display("FAIL err_status cyc=%0d err=%b err_cnt=%0d expected err=%b err_cnt=%0d",
                 cyc, err, err_cnt, (CHK && errs > 0), model_cnt(errs));
      end
      case (ph)
        0: begin
          checks++;
          if (r_ready !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL op_handshake cyc=%0d r_ready=%b done=%b ready=%b expected 1 0 0",
                     cyc, r_ready, done, ready);
          end
          r_valid = (int'($urandom_range(99)) < vpct);
          if (r_valid) begin
            if (plan.size() > 0) kind = plan.pop_front();
            else if (int'($urandom_range(99)) < cpct) begin
              if (kind_def < 0) kind = int'($urandom_range(3, 1));
              else kind = kind_def;
            end else kind = 0;
            r_data = make_beat(beat, L, kind);
            if (kind != 0) errs++;
            acc++; beat++;
            if (beat == L) begin
              beat = 0;
              ph = (burst == B - 1) ? 2 : 1;
              burst++;
            end
          end else r_data = junk_beat();
        end
        1: begin
          checks++;
          if (r_ready !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL burst_gap cyc=%0d r_ready=%b done=%b ready=%b expected 0 0 0",
                     cyc, r_ready, done, ready);
          end
          r_valid = 1'($urandom); r_data = junk_beat();
          ph = 0;
        end
        2: begin
          checks++;
          if (done !== 1'b1 || r_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse cyc=%0d done=%b r_ready=%b expected 1 0", cyc, done, r_ready);
          end
          if (vpct == 100) begin
            checks++;
            if (cyc != B * (L + 1)) begin
              failures++;
              $display("FAIL done_latency cycles=%0d expected %0d", cyc, B * (L + 1));
            end
          end
          r_valid = 1'($urandom); r_data = junk_beat();
          ph = 3;
        end
        default: begin
          checks++;
          if (ready !== 1'b1 || done !== 1'b0 || r_ready !== 1'b0) begin
            failures++;
            $display("FAIL back_to_idle cyc=%0d ready=%b done=%b r_ready=%b expected 1 0 0",
                     cyc, ready, done, r_ready);
          end
          r_valid = 1'b0;
          fin = 1'b1;
        end
      endcase
      @(negedge clk);
    end
    r_valid  = 1'b0;
    exp_prev = errs;
  endtask

  task automatic test_reset();
    rst = 1'b1; r_valid = 1'b0; r_data = '0; trans = '0; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || r_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_values ready=%b r_ready=%b done=%b err=%b err_cnt=%0d expected 1 0 0 0 0",
               ready, r_ready, done, err, err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || r_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset ready=%b r_ready=%b expected 1 0", ready, r_ready);
    end
  endtask

  task automatic test_single();
    plan.delete();
    run_trans(4, 2, 0, 0, 100, 0);
  endtask

  task automatic test_corrupt_data();
    plan = '{0, 0, 1};
    run_trans(4, 2, 0, 0, 100, 0);
  endtask

  task automatic test_bad_resp_last();
    plan = '{2, 3, 0};
    run_trans(3, 1, 0, 0, 100, 0);
  endtask

  task automatic test_wrap_saturation();
    plan.delete();
    run_trans(0, 1, 100, 1, 100, 0);
  endtask

  task automatic test_reset_mid();
    plan = '{0, 3};
    run_trans(8, 1, 0, 0, 100, 5);
    plan.delete();
    run_trans(8, 1, 0, 0, 100, 0);
  endtask

  task automatic test_random();
    plan.delete();
    for (int i = 0; i < 6; i++)
      run_trans(int'($urandom_range(12, 1)), int'($urandom_range(4, 1)), 30, -1, 60, 0);
  endtask

  task automatic test_back_to_back();
    plan.delete();
    run_trans(2, 3, 20, -1, 100, 0);
    run_trans(1, 4, 0, 0, 100, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_corrupt_data();
    test_bad_resp_last();
    test_wrap_saturation();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/r_handler.md
# r_handler

Read-data consumer for the generic reader/writer traffic generator; it is the receive-side counterpart of the write-data handler. It takes one transaction descriptor (`len` beats per burst, `burst_len` bursts) and accepts R-channel beats from the slave. Each beat is checked against the generator's counting pattern and the expected `last` position, and the block reports completion and errors. It sits between the read address issuer and the top-level status registers.

## Interface
- `r_channel_t`, default `logic`: R beat struct with fields `data`, `resp[1:0]`, `last`.
- `trans_data_t`, default `logic`: descriptor struct with fields `len[7:0]` (beats per burst) and `burst_len[7:0]` (bursts per transaction).
- `clk_i`, input, 1: single clock; all logic is on its rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `r_valid_i`, input, 1: R beat valid.
- `r_data_i`, input, `r_channel_t`: R beat payload.
- `r_ready_o`, output, 1: R beat ready.
- `trans_data_i`, input, `trans_data_t`: descriptor, sampled when a transaction starts.
- `enable_i`, input, 1: start request.
- `ready_o`, output, 1: idle, so a new transaction can be accepted.
- `done_o`, output, 1: one-cycle pulse when the final burst of a transaction completes.
- `err_o`, output, 1: sticky error flag.
- `err_cnt_o`, output, 8: saturating count of erroneous beats.

## Operation
- FSM states: IDLE, OPERATION, SETUP. The state, descriptor register, beat counter (8 b), burst counter (8 b), `err_o` and `err_cnt_o` are all registered.
- **IDLE**
  - `ready_o` = 1; `r_ready_o` = 0.
  - The descriptor register continuously loads `trans_data_i`; the beat and burst counters are held at 0.
  - `enable_i` = 1 → OPERATION. On this same edge, `err_o` and `err_cnt_o` clear to 0.
- **OPERATION**
  - `r_ready_o` = 1.
  - Each accepted beat (`r_valid_i` && `r_ready_o`) increments the beat counter.
  - When the beat index equals `len`−1, the beat is the burst's final beat and the next state is SETUP.
  - Beats are never dropped or stalled by the checker.
- **SETUP** (exactly one cycle)
  - `r_ready_o` = 0; the beat counter is reset to 0.
  - If burst count == `burst_len`−1, the next state is IDLE and `done_o` = 1 for this cycle.
  - Otherwise the burst counter increments and the next state is OPERATION.
- **Beat check**: a beat is erroneous if any of these is true:
  - `data` ≠ beat index (zero-extended to the width of `data`);
  - `resp` ≠ 2'b00;
  - `last` ≠ (beat index == `len`−1).
- **Error reporting**: an erroneous beat sets `err_o` and increments `err_cnt_o`, which saturates at 255.
- **Arithmetic**: `len`−1 and `burst_len`−1 are computed modulo 2^8, so a value of 0 means 256.
- **Simultaneous events**: an erroneous final beat both counts as an error and ends the burst.
- **Reset mid-operation**: asserting `rst_i` immediately forces IDLE and zeroes all registers and counters, with no drain.

## Timing
- **Reset values**:
  - `ready_o` = 1;
  - `r_ready_o` = 0;
  - `done_o` = 0;
  - `err_o` = 0;
  - `err_cnt_o` = 0.
- **Combinational outputs**: `r_ready_o`, `ready_o` and `done_o` are decoded from the registered state only and have no combinational path from inputs.
- **Start-up**: the first beat can be accepted on the cycle after the one where `enable_i` is sampled.
- **Burst gap**: there is one bubble (SETUP) between bursts. A transaction of B bursts × L beats, with `r_valid_i` held high, takes B·(L+1) cycles from entering OPERATION until `done_o`.
- **Error latency**: `err_o` and `err_cnt_o` update on the clock edge that accepts the offending beat.
- **`done_o` to `ready_o`**: `ready_o` rises on the cycle after `done_o`.

## Configuration
- `R_HANDLER_CHECK_EN`
  - **Defined**: the beat checker and error logic are built as described above.
  - **Undefined**: `err_o` and `err_cnt_o` are tied to 0 and the checker logic is removed. Handshake, counting and `done_o` behaviour are identical in both builds.

## Structure
- **Shared package**:
  - the `trans_data_t` field layout;
  - the OKAY resp constant (2'b00);
  - the counter width constant (8);
  - the state enum shared with the write-data handler.
- **Sub-module**: `r_beat_checker`, which is combinational. It takes the beat, the beat index and `len`, and outputs a mismatch bit. It is instantiated only under `R_HANDLER_CHECK_EN`.

## Test plan
- **Single transaction**: `len`=4, `burst_len`=2, correct beats, `r_valid_i` held high → 8 beats accepted; `r_ready_o` low for one cycle after beat 3; `done_o` pulses 10 cycles after OPERATION is entered; `err_cnt_o`=0.
- **Corrupted data**: `len`=4, beat 2 `data`=7 → `err_o`=1, `err_cnt_o`=1; the transaction still completes with `done_o`.
- **Bad response and early last**: `len`=3, beat 0 `resp`=2'b10, beat 1 `last`=1 → `err_cnt_o`=2; the burst still ends on beat 2.
- **Wrap and saturation**: `len`=0 (256 beats) with all `data` wrong → `done_o` after 257 cycles; `err_cnt_o` saturates at 255.
- **Reset mid-operation**: assert `rst_i` during beat 5 of 8 → all outputs at reset values immediately; a new `enable_i` starts cleanly from beat 0.
- **Random valid and build variant**: random `r_valid_i` gaps → beat count unaffected. A build without `R_HANDLER_CHECK_EN` given corrupted beats → `err_o`=0.
